// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Full-duplex SPI master (mode 0, MSB first) that moves one KEY_LENGTH-bit
// frame per accepted start. SCLK idles low; MOSI is updated at frame start
// and on every SCLK falling edge except the last; MISO is sampled on the clk
// edge that drives SCLK high. Each SCLK phase lasts CLK_DIV clk cycles, so a
// frame completes 2*KEY_LENGTH*CLK_DIV cycles after the accepting edge.
//
// Parameters
//   KEY_LENGTH   frame length in bits (authentication key width)
//   CLK_DIV      SCLK half-period in clk cycles (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   start        request a frame; only honoured in IDLE
//   abort        cancel the frame in progress (wins over start in IDLE)
//   dataToSend   frame to transmit, captured on the edge that accepts start
//   busy         high while a frame is being shifted
//   done         one-cycle pulse when a frame completes
//   dataReceived last fully received frame; held between done pulses
//   SCLK         SPI clock to the slave
//   MOSI         serial data to the slave (0 whenever busy is low)
//   MISO         serial data from the slave
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int KEY_LENGTH = 512,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_LENGTH-1:0] dataToSend,
    output logic                  busy,
    output logic                  done,
    output logic [KEY_LENGTH-1:0] dataReceived,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    // Phase counter runs 0..CLK_DIV-1; the bit counter must reach KEY_LENGTH
    // itself, so it gets one value more than the number of bits.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(KEY_LENGTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_ALL  = CNT_W'(KEY_LENGTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCLK_LOW  = 2'd1,
        SCLK_HIGH = 2'd2,
        DONE      = 2'd3
    } stateT;

    stateT                 state,            stateNext;
    logic [DIV_W-1:0]      divCnt,           divCntNext;
    logic [CNT_W-1:0]      bitCnt,           bitCntNext;
    logic [KEY_LENGTH-1:0] txShift,          txShiftNext;
    logic [KEY_LENGTH-1:0] rxShift,          rxShiftNext;
    logic [KEY_LENGTH-1:0] dataReceivedNext;
    logic                  sclkNext;
    logic                  mosiNext;
    logic                  busyNext;
    logic                  doneNext;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            divCnt       <= '0;
            bitCnt       <= '0;
            txShift      <= '0;
            rxShift      <= '0;
            dataReceived <= '0;
            SCLK         <= 1'b0;
            MOSI         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= stateNext;
            divCnt       <= divCntNext;
            bitCnt       <= bitCntNext;
            txShift      <= txShiftNext;
            rxShift      <= rxShiftNext;
            dataReceived <= dataReceivedNext;
            SCLK         <= sclkNext;
            MOSI         <= mosiNext;
            busy         <= busyNext;
            done         <= doneNext;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext        = state;
        divCntNext       = divCnt;
        bitCntNext       = bitCnt;
        txShiftNext      = txShift;
        rxShiftNext      = rxShift;
        dataReceivedNext = dataReceived;
        sclkNext         = SCLK;
        mosiNext         = MOSI;
        busyNext         = busy;
        doneNext         = 1'b0;

        if (abort && (state == SCLK_LOW || state == SCLK_HIGH)) begin
            // Drop the frame: the bus returns to idle and dataReceived keeps
            // the previous complete frame.
            stateNext  = IDLE;
            divCntNext = '0;
            bitCntNext = '0;
            sclkNext   = 1'b0;
            mosiNext   = 1'b0;
            busyNext   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // abort has priority over start while idle
                    if (start && !abort) begin
                        stateNext   = SCLK_LOW;
                        divCntNext  = '0;
                        bitCntNext  = '0;
                        txShiftNext = dataToSend;
                        rxShiftNext = '0;
                        sclkNext    = 1'b0;
                        mosiNext    = dataToSend[KEY_LENGTH-1];
                        busyNext    = 1'b1;
                    end
                end

                SCLK_LOW: begin
                    if (divCnt == DIV_LAST) begin
                        // Rising SCLK edge: capture the MISO value present
                        // before this clk edge into the receive LSB.
                        stateNext   = SCLK_HIGH;
                        divCntNext  = '0;
                        sclkNext    = 1'b1;
                        rxShiftNext = (rxShift << 1) | KEY_LENGTH'(MISO);
                        bitCntNext  = bitCnt + 1'b1;
                    end else begin
                        divCntNext = divCnt + 1'b1;
                    end
                end

                SCLK_HIGH: begin
                    if (divCnt == DIV_LAST) begin
                        divCntNext = '0;
                        sclkNext   = 1'b0;
                        if (bitCnt == BIT_ALL) begin
                            // Last falling edge: publish the whole frame at once.
                            stateNext        = DONE;
                            mosiNext         = 1'b0;
                            busyNext         = 1'b0;
                            doneNext         = 1'b1;
                            dataReceivedNext = rxShift;
                        end else begin
                            stateNext   = SCLK_LOW;
                            txShiftNext = txShift << 1;
                            mosiNext    = txShiftNext[KEY_LENGTH-1];
                        end
                    end else begin
                        divCntNext = divCnt + 1'b1;
                    end
                end

                DONE: begin
                    // start and abort are both ignored here
                    stateNext = IDLE;
                end

                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Directed bench for spi_master. A small instance (KEY_LENGTH=8, CLK_DIV=2)
// covers reset, loopback, constant MISO, ignored start pulses, abort and
// mid-frame reset; expected received frames go through a scoreboard queue and
// are popped on each done pulse. A second instance (KEY_LENGTH=512,
// CLK_DIV=1) talks to a behavioural mode-0 slave for the full-width frame.
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int KL        = 8;
    localparam int CD        = 2;
    localparam int FRAME_CYC = 2 * KL * CD;
    localparam int BKL       = 512;

    typedef logic [511:0] vecT;

    logic          clk   = 1'b0;
    logic          clkEn = 1'b1;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [KL-1:0] dataToSend = '0;
    logic          busy, done, sclk, mosi, miso;
    logic [KL-1:0] dataReceived;
    logic          misoLoop  = 1'b1;
    logic          misoConst = 1'b0;

    logic           startK = 1'b0;
    logic [BKL-1:0] dataK  = '0;
    logic           busyK, doneK, sclkK, mosiK, misoK;
    logic [BKL-1:0] dataReceivedK;
    logic [BKL-1:0] slaveTx = '0;

    int tests = 0;
    int fails = 0;
    logic [KL-1:0] sbQ[$];

    always #5 if (clkEn) clk = ~clk;

    assign miso  = misoLoop ? mosi : misoConst;
    assign misoK = slaveTx[BKL-1];

    spi_master #(.KEY_LENGTH(KL), .CLK_DIV(CD)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .dataToSend   (dataToSend),
        .busy         (busy),
        .done         (done),
        .dataReceived (dataReceived),
        .SCLK         (sclk),
        .MOSI         (mosi),
        .MISO         (miso)
    );

    spi_master #(.KEY_LENGTH(BKL), .CLK_DIV(1)) dutKey (
        .clk          (clk),
        .rst          (rst),
        .start        (startK),
        .abort        (1'b0),
        .dataToSend   (dataK),
        .busy         (busyK),
        .done         (doneK),
        .dataReceived (dataReceivedK),
        .SCLK         (sclkK),
        .MOSI         (mosiK),
        .MISO         (misoK)
    );

    task automatic check(input string tag, input vecT obs, input vecT exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on the small instance. Call with clk low. When
    // abortAfterRise > 0, abort is raised right after that many SCLK rises
    // and expRx is the value dataReceived must keep.
    task automatic runFrame(input string tag, input logic [KL-1:0] tx,
                            input logic [KL-1:0] expRx, input int abortAfterRise,
                            input bit pulse);
        int rises, doneAt, doneCnt, abortK, mosiErr, holdErr;
        logic prevSclk;
        logic [KL-1:0] prevRx;
        rises = 0; doneAt = -1; doneCnt = 0; abortK = -1; mosiErr = 0; holdErr = 0;
        prevSclk = 1'b0;
        prevRx   = dataReceived;
        dataToSend = tx;
        start      = 1'b1;
        if (abortAfterRise == 0) sbQ.push_back(expRx);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_e0_busy"}, vecT'(busy), vecT'(1));
        check({tag, "_e0_mosi"}, vecT'(mosi), vecT'(tx[KL-1]));
        for (int k = 1; k <= FRAME_CYC + 4; k++) begin
            @(posedge clk); #1;
            if (sclk && !prevSclk) begin
                if (rises < KL && mosi !== tx[KL-1-rises]) mosiErr++;
                rises++;
            end
            prevSclk = sclk;
            if (done) begin
                doneCnt++;
                doneAt = k;
                check({tag, "_sb_size"}, vecT'(sbQ.size()), vecT'(1));
                if (sbQ.size() > 0) check({tag, "_rx"}, vecT'(dataReceived), vecT'(sbQ.pop_front()));
                prevRx = dataReceived;
            end else if (dataReceived !== prevRx) begin
                holdErr++;
            end
            // re-pulse start mid-frame and during the done cycle
            if (pulse) start = (k == 5) || done;
            if (abortAfterRise > 0) begin
                if (abortK < 0 && rises == abortAfterRise) begin
                    abort  = 1'b1;
                    abortK = k;
                end else if (abortK >= 0 && k == abortK + 1) begin
                    abort = 1'b0;
                    check({tag, "_abort_sclk"}, vecT'(sclk), vecT'(0));
                    check({tag, "_abort_busy"}, vecT'(busy), vecT'(0));
                    check({tag, "_abort_mosi"}, vecT'(mosi), vecT'(0));
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (abortAfterRise == 0) begin
            check({tag, "_rises"},   vecT'(rises),   vecT'(KL));
            check({tag, "_doneAt"},  vecT'(doneAt),  vecT'(FRAME_CYC));
            check({tag, "_doneCnt"}, vecT'(doneCnt), vecT'(1));
            check({tag, "_mosiSeq"}, vecT'(mosiErr), vecT'(0));
            check({tag, "_rxHold"},  vecT'(holdErr), vecT'(0));
            check({tag, "_endBusy"}, vecT'(busy),    vecT'(0));
            check({tag, "_endMosi"}, vecT'(mosi),    vecT'(0));
            check({tag, "_endSclk"}, vecT'(sclk),    vecT'(0));
        end else begin
            check({tag, "_rises"},   vecT'(rises),        vecT'(abortAfterRise));
            check({tag, "_doneCnt"}, vecT'(doneCnt),      vecT'(0));
            check({tag, "_rxKept"},  vecT'(dataReceived), vecT'(expRx));
            check({tag, "_rxHold"},  vecT'(holdErr),      vecT'(0));
        end
    endtask

    initial begin
        logic [BKL-1:0] key, resp, slaveRx;
        int riseK, doneAtK, doneCntK, doneSeen;
        logic prevK;

        // Reset applied asynchronously
        #2 rst = 1'b0;
        #1;
        check("rst_busy", vecT'(busy), vecT'(0));
        check("rst_done", vecT'(done), vecT'(0));
        check("rst_sclk", vecT'(sclk), vecT'(0));
        check("rst_mosi", vecT'(mosi), vecT'(0));
        check("rst_rx",   vecT'(dataReceived), vecT'(0));

        // First start accepted on the first edge after reset release
        @(negedge clk);
        rst = 1'b1;
        runFrame("loopA5", 8'hA5, 8'hA5, 0, 1'b0);

        // Constant MISO high, then low
        @(negedge clk);
        misoLoop = 1'b0; misoConst = 1'b1;
        runFrame("miso1", 8'h5A, 8'hFF, 0, 1'b0);
        @(negedge clk);
        misoConst = 1'b0;
        runFrame("miso0", 8'hC3, 8'h00, 0, 1'b0);

        // start re-pulsed mid-frame and in the done cycle
        @(negedge clk);
        misoLoop = 1'b1;
        runFrame("pulse3C", 8'h3C, 8'h3C, 0, 1'b1);

        // abort and start together in IDLE: nothing starts
        @(negedge clk);
        dataToSend = 8'hFF; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("idleAbort_busy", vecT'(busy), vecT'(0));
        repeat (3) @(posedge clk);
        #1 check("idleAbort_sclk", vecT'(sclk), vecT'(0));

        // abort after the 3rd rise keeps the previous frame, then a clean frame
        @(negedge clk);
        runFrame("abort96", 8'h96, 8'h3C, 3, 1'b0);
        @(negedge clk);
        runFrame("after69", 8'h69, 8'h69, 0, 1'b0);

        // Reset mid-frame with the clock stopped
        @(negedge clk);
        dataToSend = 8'hF0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        clkEn = 1'b0;
        check("preRst_sclk", vecT'(sclk), vecT'(1));
        check("preRst_busy", vecT'(busy), vecT'(1));
        #2 rst = 1'b0;
        #1;
        check("midRst_sclk", vecT'(sclk), vecT'(0));
        check("midRst_mosi", vecT'(mosi), vecT'(0));
        check("midRst_busy", vecT'(busy), vecT'(0));
        check("midRst_done", vecT'(done), vecT'(0));
        check("midRst_rx",   vecT'(dataReceived), vecT'(0));
        #1 rst = 1'b1;
        clkEn = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) doneSeen++;
        end
        check("midRst_noDone", vecT'(doneSeen), vecT'(0));

        // Full-width frame against a behavioural mode-0 slave
        for (int w = 0; w < BKL / 32; w++) begin
            key[w*32 +: 32]  = $urandom;
            resp[w*32 +: 32] = $urandom;
        end
        @(negedge clk);
        slaveTx = resp;
        slaveRx = '0;
        riseK = 0; doneAtK = -1; doneCntK = 0; prevK = 1'b0;
        dataK = key; startK = 1'b1;
        @(posedge clk); #1 startK = 1'b0;
        for (int k = 1; k <= 2 * BKL + 6; k++) begin
            @(posedge clk); #1;
            if (sclkK && !prevK) begin
                slaveRx = {slaveRx[BKL-2:0], mosiK};
                riseK++;
            end
            if (!sclkK && prevK) slaveTx = slaveTx << 1;
            prevK = sclkK;
            if (doneK) begin
                doneCntK++;
                doneAtK = k;
                check("key_masterRx", vecT'(dataReceivedK), vecT'(resp));
            end
        end
        check("key_slaveRx", vecT'(slaveRx),  vecT'(key));
        check("key_rises",   vecT'(riseK),    vecT'(BKL));
        check("key_doneAt",  vecT'(doneAtK),  vecT'(2 * BKL));
        check("key_doneCnt", vecT'(doneCntK), vecT'(1));
        check("key_busy",    vecT'(busyK),    vecT'(0));

        check("sb_empty", vecT'(sbQ.size()), vecT'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
